npu_loader: RTL and testbench

NPU_LOADER -- requirements
Module: npu_loader

---
 rtl/npu_loader.sv | 179 +++++++++++++++++
 tb/tb_npu_loader.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/npu_loader.sv
// Runs one NPU inference: clears the NPU, streams image (and optionally weight) words
// from source memory, triggers, polls for completion and captures the signed logit.
module npu_loader #(
  parameter int TIMEOUT_CYCLES = 20000,
  parameter int RD_LAT         = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        load_weights,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [31:0] result,
  output logic        src_rd,
  output logic [8:0]  src_addr,
  input  logic [31:0] src_rdata,
  output logic        npu_rst_n,
  output logic        npu_ena,
  output logic        npu_wea,
  output logic [15:0] npu_addra,
  output logic [31:0] npu_dina,
  input  logic [31:0] npu_douta
);

  typedef enum logic [3:0] {
    IDLE, CLR, LOAD, TRIG, POLL_REQ, POLL_WAIT, RES_REQ, RES_WAIT, FINISH
  } state_t;

  localparam logic [15:0] TMO_LIMIT   = 16'(TIMEOUT_CYCLES);
  localparam logic [15:0] WAIT_LAST   = 16'(RD_LAT - 1);
  localparam logic [15:0] TRIG_ADDR   = {1'b0, 3'b101, 12'd1};
  localparam logic [15:0] STATUS_ADDR = {1'b0, 3'b111, 12'd0};
  localparam logic [15:0] LOGIT_ADDR  = {1'b0, 3'b111, 12'd4};

  state_t      state, state_nxt;
  logic        lw_q;
  logic [8:0]  load_cnt;
  logic [15:0] wait_cnt;
  logic [15:0] tmo_cnt;
  logic [8:0]  n_words;
  logic [8:0]  wr_word;
  logic [2:0]  wr_sel;
  logic [11:0] wr_idx;
  logic        timed_out;
  logic        wait_last;

  assign n_words   = lw_q ? 9'd439 : 9'd60;
  assign wr_word   = load_cnt - 9'd1;
  assign timed_out = (tmo_cnt >= TMO_LIMIT);
  assign wait_last = (wait_cnt == WAIT_LAST);
  assign src_addr  = load_cnt;
  assign npu_rst_n = ~rst && (state != CLR);

  // Source word number -> NPU region select and index within that region
  always_comb begin
    wr_sel = 3'b000;
    wr_idx = 12'd0;
    if (wr_word < 9'd60) begin
      wr_sel = 3'b110;
      wr_idx = {3'b000, wr_word};
    end else if (wr_word < 9'd83) begin
      wr_sel = 3'b001;
      wr_idx = {3'b000, wr_word - 9'd60};
    end else if (wr_word < 9'd106) begin
      wr_sel = 3'b010;
      wr_idx = {3'b000, wr_word - 9'd83};
    end else if (wr_word < 9'd436) begin
      wr_sel = 3'b011;
      wr_idx = {3'b000, wr_word - 9'd106};
    end else begin
      wr_sel = 3'b100;
      wr_idx = {3'b000, wr_word - 9'd436};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    src_rd    = 1'b0;
    npu_ena   = 1'b0;
    npu_wea   = 1'b0;
    npu_addra = 16'd0;
    npu_dina  = 32'd0;
    case (state)
      IDLE: if (start) state_nxt = CLR;
      CLR: begin
        busy = 1'b1;
        if (wait_cnt == 16'd1) state_nxt = LOAD;
      end
      LOAD: begin
        // Read of word k overlaps the write of word k-1, so a load costs N+1 cycles
        busy   = 1'b1;
        src_rd = (load_cnt < n_words);
        if (load_cnt != 9'd0) begin
          npu_ena   = 1'b1;
          npu_wea   = 1'b1;
          npu_addra = {1'b0, wr_sel, wr_idx};
          npu_dina  = src_rdata;
        end
        if (load_cnt == n_words) state_nxt = TRIG;
      end
      TRIG: begin
        busy      = 1'b1;
        npu_ena   = 1'b1;
        npu_wea   = 1'b1;
        npu_addra = TRIG_ADDR;
        state_nxt = POLL_REQ;
      end
      POLL_REQ: begin
        busy = 1'b1;
        if (timed_out) begin
          state_nxt = FINISH;
        end else begin
          npu_ena   = 1'b1;
          npu_addra = STATUS_ADDR;
          state_nxt = POLL_WAIT;
        end
      end
      POLL_WAIT: begin
        busy = 1'b1;
        if (timed_out)      state_nxt = FINISH;
        else if (wait_last) state_nxt = npu_douta[0] ? RES_REQ : POLL_REQ;
      end
      RES_REQ: begin
        busy      = 1'b1;
        npu_ena   = 1'b1;
        npu_addra = LOGIT_ADDR;
        state_nxt = RES_WAIT;
      end
      RES_WAIT: begin
        busy = 1'b1;
        if (wait_last) state_nxt = FINISH;
      end
      FINISH: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Counters, run configuration and the result/error registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lw_q     <= 1'b0;
      load_cnt <= 9'd0;
      wait_cnt <= 16'd0;
      tmo_cnt  <= 16'd0;
      error    <= 1'b0;
      result   <= 32'd0;
    end else begin
      load_cnt <= (state == LOAD && state_nxt == LOAD) ? load_cnt + 9'd1 : 9'd0;
      if (state_nxt != state)
        wait_cnt <= 16'd0;
      else if (state inside {CLR, POLL_WAIT, RES_WAIT})
        wait_cnt <= wait_cnt + 16'd1;
      if (state == IDLE && start) begin
        lw_q    <= load_weights;
        error   <= 1'b0;
        result  <= 32'd0;
        tmo_cnt <= 16'd0;
      end
      if (state inside {TRIG, POLL_REQ, POLL_WAIT, RES_REQ, RES_WAIT} && tmo_cnt != 16'hFFFF)
        tmo_cnt <= tmo_cnt + 16'd1;
      if ((state == POLL_REQ || state == POLL_WAIT) && timed_out)
        error <= 1'b1;
      if (state == RES_WAIT && wait_last)
        result <= npu_douta;
    end
  end

endmodule

// File: tb/tb_npu_loader.sv
// Drives npu_loader against a source-memory model and a behavioural NPU model, and checks
// each run against a table of expected outcomes plus a segment-based write-sequence model.
module tb_npu_loader;

  localparam int TMO = 50;
  localparam int RDL = 2;
  localparam logic [15:0] TRIG_ADDR   = 16'h5001;
  localparam logic [15:0] STATUS_ADDR = 16'h7000;
  localparam logic [15:0] LOGIT_ADDR  = 16'h7004;
  localparam logic [31:0] GARBAGE     = 32'hA5A5_A5A4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        load_weights = 1'b0;
  logic        busy, done, error;
  logic [31:0] result;
  logic        src_rd;
  logic [8:0]  src_addr;
  logic [31:0] src_rdata;
  logic        npu_rst_n, npu_ena, npu_wea;
  logic [15:0] npu_addra;
  logic [31:0] npu_dina;
  logic [31:0] npu_douta;

  npu_loader #(.TIMEOUT_CYCLES(TMO), .RD_LAT(RDL)) dut (
    .clk(clk), .rst(rst), .start(start), .load_weights(load_weights),
    .busy(busy), .done(done), .error(error), .result(result),
    .src_rd(src_rd), .src_addr(src_addr), .src_rdata(src_rdata),
    .npu_rst_n(npu_rst_n), .npu_ena(npu_ena), .npu_wea(npu_wea),
    .npu_addra(npu_addra), .npu_dina(npu_dina), .npu_douta(npu_douta)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] addr;
    logic [31:0] data;
    int          cyc;
  } wr_t;

  typedef struct {
    logic        lw;
    int          done_poll;
    logic [31:0] logit;
    logic        ramp_src;
    int          extra_start;
    int          exp_writes;
    logic        exp_error;
    logic [31:0] exp_result;
    int          exp_polls;
  } run_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Source memory with one cycle of read latency; idle cycles return noise
  logic [31:0] src_mem [512];
  always @(posedge clk) src_rdata <= src_rd ? src_mem[src_addr] : $urandom();

  // NPU model: sticky done set on the Nth status poll after a trigger, cleared by npu_rst_n
  int          model_done_poll = 3;
  logic [31:0] model_logit = 32'd0;
  int          npu_polls = 0;
  logic        npu_done_flag = 1'b0;
  logic        npu_trig_seen = 1'b0;
  logic [31:0] pipe_data [RDL];
  logic        pipe_vld  [RDL];
  logic [31:0] req_data;
  logic        now_done;

  always @(posedge clk) begin
    if (!npu_rst_n) begin
      npu_polls     <= 0;
      npu_done_flag <= 1'b0;
      npu_trig_seen <= 1'b0;
      for (int i = 0; i < RDL; i++) pipe_vld[i] <= 1'b0;
    end else begin
      req_data = GARBAGE;
      if (npu_ena && npu_wea && npu_addra == TRIG_ADDR) npu_trig_seen <= 1'b1;
      if (npu_ena && !npu_wea && npu_addra == STATUS_ADDR) begin
        now_done = npu_done_flag ||
                   (npu_trig_seen && model_done_poll != 0 && npu_polls + 1 >= model_done_poll);
        npu_polls <= npu_polls + 1;
        if (now_done) npu_done_flag <= 1'b1;
        req_data = {31'd0, now_done};
      end else if (npu_ena && !npu_wea && npu_addra == LOGIT_ADDR) begin
        req_data = model_logit;
      end
      pipe_vld[0]  <= npu_ena && !npu_wea;
      pipe_data[0] <= req_data;
      for (int i = 1; i < RDL; i++) begin
        pipe_vld[i]  <= pipe_vld[i-1];
        pipe_data[i] <= pipe_data[i-1];
      end
    end
  end
  assign npu_douta = pipe_vld[RDL-1] ? pipe_data[RDL-1] : GARBAGE;

  // Bus monitor
  logic mon_en = 1'b0;
  wr_t  wr_q[$];
  int   rstn_low, done_cnt, done_cyc, busy_at_done, rd_cnt, rd_order_err, idle_viol;
  always @(negedge clk) begin
    if (mon_en) begin
      if (npu_ena && npu_wea) begin
        wr_t w;
        w.addr = npu_addra;
        w.data = npu_dina;
        w.cyc  = cyc;
        wr_q.push_back(w);
      end
      if (!npu_ena && (npu_wea || npu_dina != 32'd0)) idle_viol++;
      if (!npu_rst_n) rstn_low++;
      if (src_rd) begin
        if (src_addr != 9'(rd_cnt)) rd_order_err++;
        rd_cnt++;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        if (busy) busy_at_done++;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual 0x%08h required 0x%08h", name, actual, expected);
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
    checkOutput({tag, "_done"}, 32'(done), 32'd0);
    checkOutput({tag, "_error"}, 32'(error), 32'd0);
    checkOutput({tag, "_result"}, result, 32'd0);
    checkOutput({tag, "_src_rd"}, 32'(src_rd), 32'd0);
    checkOutput({tag, "_src_addr"}, 32'(src_addr), 32'd0);
    checkOutput({tag, "_npu_ena"}, 32'(npu_ena), 32'd0);
    checkOutput({tag, "_npu_wea"}, 32'(npu_wea), 32'd0);
    checkOutput({tag, "_npu_addra"}, 32'(npu_addra), 32'd0);
    checkOutput({tag, "_npu_dina"}, npu_dina, 32'd0);
    checkOutput({tag, "_npu_rst_n"}, 32'(npu_rst_n), 32'd0);
  endtask

  task automatic clearMonitor();
    wr_q.delete();
    rstn_low = 0; done_cnt = 0; done_cyc = 0; busy_at_done = 0;
    rd_cnt = 0; rd_order_err = 0; idle_viol = 0;
  endtask

  task automatic applyStimulus(input run_t r, input int id);
    int   seg_sel[5];
    int   seg_len[5];
    wr_t  exp_q[$];
    wr_t  e;
    int   n_total, w, n, mism, start_cyc, trig_cyc, d;
    logic seen;
    seg_sel = '{6, 1, 2, 3, 4};
    seg_len = '{60, 23, 23, 330, 3};
    for (int k = 0; k < 512; k++) src_mem[k] = r.ramp_src ? 32'(k) : $urandom();
    model_done_poll = r.done_poll;
    model_logit     = r.logit;
    clearMonitor();
    $display("[TB] run %0d: load_weights=%0d done_poll=%0d", id, r.lw, r.done_poll);

    @(negedge clk);
    mon_en = 1'b1;
    start = 1'b1;
    load_weights = r.lw;
    start_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
    load_weights = 1'($urandom_range(0, 1));
    checkOutput("clr_busy", 32'(busy), 32'd1);
    checkOutput("clr_error_cleared", 32'(error), 32'd0);
    checkOutput("clr_result_cleared", result, 32'd0);

    seen = 1'b0;
    n = 0;
    while (!seen && n < 3000) begin
      @(negedge clk);
      n++;
      if (done) seen = 1'b1;
      start = (!seen && r.extra_start != 0 && n == r.extra_start) ? 1'b1 : 1'b0;
    end
    start = 1'b0;
    checkOutput("done_within_bound", 32'(seen), 32'd1);
    repeat (5) @(negedge clk);
    mon_en = 1'b0;

    checkOutput("done_pulse_count", 32'(done_cnt), 32'd1);
    checkOutput("busy_low_at_done", 32'(busy_at_done), 32'd0);
    checkOutput("busy_after_run", 32'(busy), 32'd0);
    checkOutput("error", 32'(error), 32'(r.exp_error));
    checkOutput("result", result, r.exp_result);
    checkOutput("npu_rst_n_low_cycles", 32'(rstn_low), 32'd2);
    checkOutput("src_read_count", 32'(rd_cnt), 32'(r.exp_writes));
    checkOutput("src_read_order", 32'(rd_order_err), 32'd0);
    checkOutput("idle_bus_quiet", 32'(idle_viol), 32'd0);

    // Expected write stream: segments in source order, then the trigger write
    n_total = r.lw ? 439 : 60;
    w = 0;
    for (int s = 0; s < 5; s++) begin
      for (int i = 0; i < seg_len[s]; i++) begin
        if (w < n_total) begin
          e.addr = {1'b0, 3'(seg_sel[s]), 12'(i)};
          e.data = src_mem[w];
          e.cyc  = 0;
          exp_q.push_back(e);
        end
        w++;
      end
    end
    e.addr = TRIG_ADDR;
    e.data = 32'd0;
    exp_q.push_back(e);

    checkOutput("write_count", 32'(wr_q.size()), 32'(r.exp_writes + 1));
    mism = 0;
    for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++) begin
      if (wr_q[i].addr !== exp_q[i].addr || wr_q[i].data !== exp_q[i].data) begin
        if (mism == 0)
          $display("[TB] first bad write #%0d: addr %h data %h, want addr %h data %h",
                   i, wr_q[i].addr, wr_q[i].data, exp_q[i].addr, exp_q[i].data);
        mism++;
      end
    end
    checkOutput("write_sequence_mismatches", 32'(mism), 32'd0);

    if (wr_q.size() > 0) begin
      trig_cyc = wr_q[$].cyc;
      checkOutput("first_write_latency", 32'(wr_q[0].cyc - start_cyc), 32'd4);
      checkOutput("writes_without_bubbles", 32'(wr_q[$].cyc - wr_q[0].cyc), 32'(exp_q.size() - 1));
      d = done_cyc - trig_cyc;
      if (!r.exp_error) begin
        checkOutput("done_latency", 32'(d), 32'((1 + RDL) * r.done_poll + RDL + 2));
        checkOutput("poll_count", 32'(npu_polls), 32'(r.exp_polls));
      end else begin
        checkOutput("timeout_window", 32'(d >= TMO && d <= TMO + RDL + 2), 32'd1);
      end
    end
  endtask

  run_t runs[8];
  run_t r;
  int   n;

  initial begin
    // Fixed scenarios, then randomized ones whose expectations come from the same rules
    runs[0] = '{1'b1, 3, 32'hFFFF_FFFB, 1'b1, 0,   439, 1'b0, 32'hFFFF_FFFB, 3};
    runs[1] = '{1'b0, 3, 32'h0000_1234, 1'b0, 0,   60,  1'b0, 32'h0000_1234, 3};
    runs[2] = '{1'b1, 0, 32'h0000_7777, 1'b0, 0,   439, 1'b1, 32'h0000_0000, 0};
    runs[3] = '{1'b1, 2, 32'h8000_0001, 1'b0, 150, 439, 1'b0, 32'h8000_0001, 2};
    runs[4] = '{1'b0, 4, 32'h0000_0042, 1'b0, 20,  60,  1'b0, 32'h0000_0042, 4};
    for (int i = 5; i < 8; i++) begin
      r.lw          = 1'($urandom_range(0, 1));
      r.done_poll   = int'($urandom_range(1, 4));
      r.logit       = $urandom();
      r.ramp_src    = 1'b0;
      r.extra_start = ($urandom_range(0, 1) == 1) ? int'($urandom_range(5, 70)) : 0;
      r.exp_writes  = r.lw ? 439 : 60;
      r.exp_error   = 1'b0;
      r.exp_result  = r.logit;
      r.exp_polls   = r.done_poll;
      runs[i] = r;
    end

    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    checkResetOutputs("por");
    rst = 1'b0;
    #1 checkOutput("npu_rst_n_after_reset", 32'(npu_rst_n), 32'd1);

    for (int i = 0; i < 8; i++) applyStimulus(runs[i], i);

    // Reset in the middle of LOAD: everything drops at once, no done pulse follows
    for (int k = 0; k < 512; k++) src_mem[k] = $urandom();
    model_done_poll = 3;
    clearMonitor();
    mon_en = 1'b1;
    @(negedge clk);
    start = 1'b1;
    load_weights = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!(src_rd && src_addr == 9'd200) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    checkOutput("reached_word_200", 32'(src_addr), 32'd200);
    #2 rst = 1'b1;
    #1 checkResetOutputs("midload");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1 checkOutput("npu_rst_n_after_midload", 32'(npu_rst_n), 32'd1);
    repeat (4) @(negedge clk);
    checkOutput("no_done_after_abort", 32'(done_cnt), 32'd0);
    checkOutput("idle_after_abort", 32'(busy), 32'd0);
    mon_en = 1'b0;

    r = '{1'b1, 2, 32'h0BAD_F00D, 1'b1, 0, 439, 1'b0, 32'h0BAD_F00D, 2};
    applyStimulus(r, 8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
